// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter
// ----------------------------------------------------------------------------
// Shares one data memory between two requesters:
//   port 0 : processor load/store path
//   port 1 : DMA / loader path
// Requests are serialised with round-robin fairness. Each access walks
// IDLE -> REQ -> WAIT -> RESP: the strobe is held in REQ until the memory
// raises mem_busy, WAIT then holds until mem_busy falls, and RESP emits a
// one-cycle ack to the granted port. Read data is registered per port.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   rN_read / rN_write    request levels (write wins if both are high)
//   rN_addr / rN_wdata    request address / write data (latched in IDLE)
//   rN_rdata              registered read data for port N
//   rN_ack                one-cycle completion pulse
//   rN_busy               stall: request high and not completing this cycle
//   mem_read/mem_write    memory strobes (high only in REQ)
//   mem_addr/mem_wdata    latched address / write data
//   mem_rdata, mem_busy   memory read data and busy handshake
//   err                   sticky timeout flag
//
// Optional feature (macro DMEM_ARB_TIMEOUT_EN):
//   When defined, an access that stays in REQ+WAIT for TIMEOUT cycles is
//   aborted: it is acked, a read returns all ones, and err is set until
//   RESET. When undefined, REQ/WAIT wait forever and err is tied low.
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_ack,
    output logic              r0_busy,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_ack,
    output logic              r1_busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_grant;       // port currently being served
    logic   r_last_grant;  // port served most recently (resets to 1 so port 0 wins the first tie)
    logic   r_op_wr;       // 1 = write, 0 = read

    logic w_req0;
    logic w_req1;
    logic w_pick;
    logic w_pick_wr;
    logic w_active;
    logic w_done;
    logic w_tmo;
    logic w_abort;

    assign w_req0 = r0_read | r0_write;
    assign w_req1 = r1_read | r1_write;

    // Tie goes to the port that was not served last; otherwise the lone requester.
    assign w_pick    = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
    // Write has priority over read on the same port.
    assign w_pick_wr = w_pick ? r1_write : r0_write;

    assign w_active = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_done   = (r_state == S_WAIT) && !mem_busy;
    // A normal completion in the same cycle as the timeout takes precedence.
    assign w_abort  = w_tmo && !w_done;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_err;

    assign w_tmo = w_active && (r_tmo_cnt >= CNT_W'(TIMEOUT - 1));
    assign err   = r_err;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_IDLE)
                r_tmo_cnt <= '0;
            else if (w_active)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_abort)
                r_err <= 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req0 || w_req1)
                    w_state_nxt = S_REQ;
            end
            S_REQ: begin
                // Timeout is checked first so the counter cannot run past
                // the limit while the handshake is still pending.
                if (w_tmo)
                    w_state_nxt = S_RESP;
                else if (mem_busy)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!mem_busy || w_tmo)
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op_wr      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            r0_rdata     <= '0;
            r1_rdata     <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Address, data and op are frozen at grant; later changes on the
            // request lines are ignored until the next IDLE visit.
            if (r_state == S_IDLE && (w_req0 || w_req1)) begin
                r_grant   <= w_pick;
                r_op_wr   <= w_pick_wr;
                mem_addr  <= w_pick ? r1_addr  : r0_addr;
                mem_wdata <= w_pick ? r1_wdata : r0_wdata;
            end

            if (!r_op_wr) begin
                if (w_done) begin
                    if (r_grant) r1_rdata <= mem_rdata;
                    else         r0_rdata <= mem_rdata;
                end else if (w_abort) begin
                    if (r_grant) r1_rdata <= '1;
                    else         r0_rdata <= '1;
                end
            end

            if (r_state == S_RESP)
                r_last_grant <= r_grant;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_read  = (r_state == S_REQ) && !r_op_wr;
    assign mem_write = (r_state == S_REQ) &&  r_op_wr;

    assign r0_ack  = (r_state == S_RESP) && !r_grant;
    assign r1_ack  = (r_state == S_RESP) &&  r_grant;

    assign r0_busy = w_req0 && !r0_ack;
    assign r1_busy = w_req1 && !r1_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized two-port
// phase. Requests push expected transactions into per-port queues; a monitor
// pops them on each ack and checks read data against a shadow memory that is
// updated in ack order.
module tb_dmem_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          r0_read = 1'b0, r0_write = 1'b0, r1_read = 1'b0, r1_write = 1'b0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          r0_ack, r1_ack, r0_busy, r1_busy;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_busy;
    logic          err;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET),
        .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rdata(r0_rdata), .r0_ack(r0_ack), .r0_busy(r0_busy),
        .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rdata(r1_rdata), .r1_ack(r1_ack), .r1_busy(r1_busy),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy), .err(err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory device model ----------------
    logic [7:0] mem_arr [256];
    logic       m_busy = 1'b0;
    int         m_cnt = 0;
    int         m_lat = 3;
    bit         rand_lat = 0;
    bit         stuck = 0;
    logic [7:0] m_rdata = '0;

    assign mem_busy  = m_busy | stuck;
    assign mem_rdata = m_rdata;

    // Busy rises the cycle after a strobe is sampled and stays high m_lat cycles.
    always @(posedge CLK) begin
        if (RESET) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (m_busy) begin
            if (m_cnt <= 1) m_busy <= 1'b0;
            m_cnt <= m_cnt - 1;
        end else if (mem_read || mem_write) begin
            m_busy <= 1'b1;
            m_cnt  <= rand_lat ? int'($urandom_range(1, 4)) : m_lat;
            if (mem_write) mem_arr[mem_addr] <= mem_wdata;
            else           m_rdata <= mem_arr[mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t       q0[$];
    txn_t       q1[$];
    logic [7:0] shadow [256];
    logic [7:0] last_rd [2];
    bit         tmo_exp = 0;
    int         ack_log[$];
    int         rd_strobes = 0;

    task automatic handle_ack(input int p, input logic [7:0] rdata);
        txn_t t;
        logic [7:0] e;
        if (p == 0 && q0.size() == 0 || p == 1 && q1.size() == 0) begin
            chk($sformatf("unexpected_ack_p%0d", p), 1, 0);
            return;
        end
        t = (p == 0) ? q0.pop_front() : q1.pop_front();
        ack_log.push_back(p);
        if (t.wr) begin
            if (!tmo_exp) shadow[t.addr] = t.data;
            chk($sformatf("rdata_kept_on_write_p%0d", p), rdata, last_rd[p]);
        end else begin
            e = tmo_exp ? 8'hFF : shadow[t.addr];
            chk($sformatf("rdata_p%0d_a%0h", p, t.addr), rdata, e);
            last_rd[p] = e;
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RESET) begin
                last_rd[0] = '0;
                last_rd[1] = '0;
            end
            if (mem_read) rd_strobes++;
            chk("strobe_exclusive", {31'd0, mem_read & mem_write}, 0);
            chk("r0_busy", r0_busy, (r0_read | r0_write) & ~r0_ack);
            chk("r1_busy", r1_busy, (r1_read | r1_write) & ~r1_ack);
            if (r0_ack) handle_ack(0, r0_rdata);
            if (r1_ack) handle_ack(1, r1_rdata);
        end
    end

    // ---------------- requester helpers ----------------
    // Called at a negedge: queue the expectation and raise the request.
    task automatic raise(input int p, input int op, input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        t.wr = (op != 0);
        t.addr = a;
        t.data = d;
        if (p == 0) begin
            q0.push_back(t);
            r0_read = (op != 1); r0_write = (op != 0); r0_addr = a; r0_wdata = d;
        end else begin
            q1.push_back(t);
            r1_read = (op != 1); r1_write = (op != 0); r1_addr = a; r1_wdata = d;
        end
    endtask

    task automatic wait_ack(input int p, input bit scramble, output int lat, output int foreign);
        int  k = -1;
        bit  got = 0;
        lat = 0;
        foreign = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge CLK);
            #1;
            if (k < 0) k = cyc;
            if (i == 0 && scramble) begin
                if (p == 0) begin r0_addr = r0_addr ^ 8'h5A; r0_wdata = ~r0_wdata; end
                else        begin r1_addr = r1_addr ^ 8'h5A; r1_wdata = ~r1_wdata; end
            end
            if ((p == 0) ? r0_ack : r1_ack) begin
                got = 1;
                lat = cyc + 1 - k;
            end else if ((p == 0) ? r1_ack : r0_ack) begin
                foreign++;
            end
        end
        chk($sformatf("ack_seen_p%0d", p), {31'd0, got}, 1);
        @(negedge CLK);
        if (p == 0) begin r0_read = 0; r0_write = 0; end
        else        begin r1_read = 0; r1_write = 0; end
    endtask

    task automatic do_req(input int p, input int op, input logic [7:0] a, input logic [7:0] d,
                          input bit scramble, output int lat, output int foreign);
        @(negedge CLK);
        raise(p, op, a, d);
        wait_ack(p, scramble, lat, foreign);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1;
        @(negedge CLK);
        RESET = 0;
    endtask

    task automatic check_order(input string name, input int e0, input int e1, input int e2, input int e3, input int n);
        int exp[4];
        exp = '{e0, e1, e2, e3};
        chk({name, "_count"}, ack_log.size(), n);
        for (int i = 0; i < n && i < ack_log.size(); i++)
            chk($sformatf("%s_%0d", name, i), ack_log[i], exp[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat, fo, lat2, fo2, n;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 8'($urandom);
            shadow[i]  = mem_arr[i];
        end
        last_rd[0] = '0;
        last_rd[1] = '0;
        mem_arr[4] = 8'h20;
        shadow[4]  = 8'h20;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_r0_rdata", r0_rdata, 0);
        chk("rst_r1_rdata", r1_rdata, 0);
        chk("rst_acks", {r0_ack, r1_ack}, 0);
        chk("rst_err", err, 0);
        RESET = 0;

        // Single read with ignored post-latch address change
        do_req(0, 0, 8'h04, 8'h00, 1, lat, fo);
        chk("read_latency", lat, 6);
        chk("read_value", r0_rdata, 8'h20);

        // Write then read on port 1
        do_req(1, 1, 8'h06, 8'h08, 1, lat, fo);
        chk("mem6_written", mem_arr[6], 8'h08);
        chk("write_latency", lat, 6);
        do_req(1, 0, 8'h06, 8'h00, 0, lat, fo);
        chk("r1_read_back", r1_rdata, 8'h08);

        // Simultaneous requests from reset, held back to back
        pulse_reset();
        ack_log.delete();
        fork
            begin
                for (int i = 0; i < 2; i++) do_req(0, 0, 8'(i), 8'h00, 0, lat, fo);
            end
            begin
                for (int i = 0; i < 2; i++) do_req(1, 0, 8'(i + 8), 8'h00, 0, lat2, fo2);
            end
        join
        check_order("alt_order", 0, 1, 0, 1, 4);

        // After port 0 is served alone, a tie goes to port 1
        do_req(0, 0, 8'h04, 8'h00, 0, lat, fo);
        ack_log.delete();
        fork
            do_req(0, 0, 8'h05, 8'h00, 0, lat, fo);
            do_req(1, 0, 8'h06, 8'h00, 0, lat2, fo2);
        join
        check_order("tie_order", 1, 0, 0, 0, 2);

        // Read and write both high: write wins
        rd_strobes = 0;
        do_req(0, 2, 8'h02, 8'h55, 0, lat, fo);
        chk("both_no_mem_read", rd_strobes, 0);
        chk("both_mem2", mem_arr[2], 8'h55);

        // Reset during WAIT
        do_req(0, 0, 8'h04, 8'h00, 0, lat, fo);
        m_lat = 6;
        @(negedge CLK);
        raise(0, 0, 8'h04, 8'h00);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RESET = 1;
        @(posedge CLK);
        #1;
        chk("rstw_strobes", {mem_read, mem_write}, 0);
        chk("rstw_no_ack", r0_ack, 0);
        chk("rstw_rdata", r0_rdata, 0);
        @(negedge CLK);
        RESET = 0;
        @(posedge CLK);
        #1;
        chk("rstw_reissue_strobe", mem_read, 1);
        wait_ack(0, 0, lat, fo);
        chk("rstw_reissue_value", r0_rdata, 8'h20);
        m_lat = 3;

        // Memory stuck busy
        stuck = 1;
`ifdef DMEM_ARB_TIMEOUT_EN
        tmo_exp = 1;
        do_req(0, 0, 8'h03, 8'h00, 0, lat, fo);
        chk("tmo_latency", lat, TMO + 1);
        chk("tmo_err_set", err, 1);
        repeat (3) @(posedge CLK);
        #1;
        chk("tmo_err_sticky", err, 1);
        tmo_exp = 0;
        stuck = 0;
        pulse_reset();
        chk("tmo_err_cleared", err, 0);
`else
        @(negedge CLK);
        r0_read = 1;
        r0_addr = 8'h03;
        n = 0;
        repeat (60) begin
            @(posedge CLK);
            #1;
            if (r0_ack) n++;
        end
        chk("stuck_no_ack", n, 0);
        chk("stuck_err_low", err, 0);
        @(negedge CLK);
        r0_read = 0;
        RESET = 1;
        stuck = 0;
        @(negedge CLK);
        RESET = 0;
`endif

        // Randomized two-port traffic with random memory latency
        rand_lat = 1;
        fork
            begin
                int l, f;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge CLK);
                    do_req(0, int'($urandom_range(0, 2)), 8'($urandom_range(0, 7)), 8'($urandom), 0, l, f);
                    chk("fair_p0", {31'd0, f <= 1}, 1);
                end
            end
            begin
                int l, f;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge CLK);
                    do_req(1, int'($urandom_range(0, 2)), 8'($urandom_range(0, 7)), 8'($urandom), 0, l, f);
                    chk("fair_p1", {31'd0, f <= 1}, 1);
                end
            end
        join
        repeat (5) @(posedge CLK);
        chk("queues_drained", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
